// File: rtl/j_sb_pkg.sv
// Shared types and defaults for the j_sb register scoreboard.
package j_sb_pkg;

  localparam int REGW        = 6;
  localparam int ENTRIES_DEF = 4;
  localparam int TAGW_DEF    = 2;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/j_cmp6.sv
// 6-bit equality comparator used for register-address matching.
module j_cmp6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/j_sb_entry.sv
// One scoreboard slot: pending-write record plus its RAW/WAW match logic.
module j_sb_entry
  import j_sb_pkg::*;
(
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc,
  input  logic            retire,
  input  logic [REGW-1:0] srca,
  input  logic            usea,
  input  logic [REGW-1:0] srcb,
  input  logic            useb,
  input  logic [REGW-1:0] dst,
  input  logic            wr,
  output logic            hit,
  output logic            valid
);

  sb_entry_t entry_q, entry_d;
  logic      eq_a, eq_b, eq_w;

  j_cmp6 u_cmp_a (.a(entry_q.dst), .b(srca), .eq(eq_a));
  j_cmp6 u_cmp_b (.a(entry_q.dst), .b(srcb), .eq(eq_b));
  j_cmp6 u_cmp_w (.a(entry_q.dst), .b(dst),  .eq(eq_w));

  // Alloc only targets a free slot and retire only a valid one, so they never collide here.
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d.valid = 1'b0;
    end else if (alloc) begin
      entry_d.valid = 1'b1;
      entry_d.dst   = dst;
    end else if (retire) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign valid = entry_q.valid;
  assign hit   = entry_q.valid & ((eq_a & usea) | (eq_b & useb) | (eq_w & wr));

endmodule

// File: rtl/j_sb.sv
// Jerry issue-stage register scoreboard. JERRY_SB_BYPASS_EN lets a retiring entry stop stalling in its own cycle.
module j_sb
  import j_sb_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int TAGW    = TAGW_DEF
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [REGW-1:0] iss_srca,
  input  logic            iss_usea,
  input  logic [REGW-1:0] iss_srcb,
  input  logic            iss_useb,
  input  logic [REGW-1:0] iss_dst,
  input  logic            iss_wr,
  output logic [TAGW-1:0] iss_tag,
  input  logic            ret_valid,
  input  logic [TAGW-1:0] ret_tag,
  input  logic            flush,
  output logic            busy,
  output logic            full,
  output logic            ret_err
);

  logic [ENTRIES-1:0] hit, valid, excl, alloc, retire;
  logic [TAGW-1:0]    free_tag;
  logic               hazard, fire;
  logic               ret_err_q, ret_err_d;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    j_sb_entry u_ent (
      .sys_clk (sys_clk),
      .reset   (reset),
      .flush   (flush),
      .alloc   (alloc[e]),
      .retire  (retire[e]),
      .srca    (iss_srca),
      .usea    (iss_usea),
      .srcb    (iss_srcb),
      .useb    (iss_useb),
      .dst     (iss_dst),
      .wr      (iss_wr),
      .hit     (hit[e]),
      .valid   (valid[e])
    );
  end

`ifdef JERRY_SB_BYPASS_EN
  // Retiring entry's value reaches the reader through register-file write-through.
  always_comb begin
    excl = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      excl[e] = ret_valid & (ret_tag == TAGW'(e)) & ~flush;
    end
  end
`else
  assign excl = '0;
`endif

  always_comb begin
    free_tag = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) free_tag = TAGW'(i);
    end
  end

  assign full      = &valid;
  assign busy      = |valid;
  assign hazard    = |(hit & ~excl);
  assign iss_ready = ~hazard & ~flush & (~iss_wr | ~full);
  assign iss_tag   = free_tag;
  assign fire      = iss_valid & iss_ready;

  always_comb begin
    alloc  = '0;
    retire = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      alloc[e]  = fire & iss_wr & (free_tag == TAGW'(e));
      retire[e] = ret_valid & (ret_tag == TAGW'(e)) & valid[e];
    end
  end

  assign ret_err_d = ret_valid & ~valid[ret_tag] & ~flush;

  always_ff @(posedge sys_clk) begin
    if (reset) ret_err_q <= 1'b0;
    else       ret_err_q <= ret_err_d;
  end

  assign ret_err = ret_err_q;

endmodule

// File: tb/tb_j_sb.sv
// Self-checking bench for j_sb: directed scenarios plus random traffic against a slot-list model.
module tb_j_sb;

  localparam int N = 4;

`ifdef JERRY_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       iss_valid, iss_usea, iss_useb, iss_wr;
  logic       iss_ready;
  logic [5:0] iss_srca, iss_srcb, iss_dst;
  logic [1:0] iss_tag, ret_tag;
  logic       ret_valid, flush, busy, full, ret_err;

  int n_cmp = 0;
  int n_err = 0;

  // pend[e] = pending destination address of slot e, or -1 when the slot is free
  int pend[N];
  bit exp_err;

  always #5 sys_clk = ~sys_clk;

  j_sb dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_srca  (iss_srca),
    .iss_usea  (iss_usea),
    .iss_srcb  (iss_srcb),
    .iss_useb  (iss_useb),
    .iss_dst   (iss_dst),
    .iss_wr    (iss_wr),
    .iss_tag   (iss_tag),
    .ret_valid (ret_valid),
    .ret_tag   (ret_tag),
    .flush     (flush),
    .busy      (busy),
    .full      (full),
    .ret_err   (ret_err)
  );

  function automatic bit m_hazard();
    for (int e = 0; e < N; e++) begin
      if (pend[e] < 0) continue;
      if (BYP && ret_valid && int'(ret_tag) == e && !flush) continue;
      if ((iss_usea && pend[e] == int'(iss_srca)) ||
          (iss_useb && pend[e] == int'(iss_srcb)) ||
          (iss_wr   && pend[e] == int'(iss_dst)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int e = 0; e < N; e++) if (pend[e] >= 0) c++;
    return c;
  endfunction

  function automatic int m_tag();
    for (int e = 0; e < N; e++) if (pend[e] < 0) return e;
    return 0;
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && !flush && (!iss_wr || m_count() < N);
  endfunction

  task automatic idle();
    iss_valid = 0; iss_usea = 0; iss_useb = 0; iss_wr = 0;
    iss_srca = 0; iss_srcb = 0; iss_dst = 0;
    ret_valid = 0; ret_tag = 0; flush = 0;
  endtask

  // Advance one clock, applying the scoreboard rules to the model at the edge.
  task automatic step();
    bit fire, bad;
    int t;
    fire = iss_valid && m_ready();
    t    = m_tag();
    bad  = ret_valid && pend[ret_tag] < 0 && !flush && !reset;
    @(posedge sys_clk);
    if (reset || flush) begin
      for (int e = 0; e < N; e++) pend[e] = -1;
    end else begin
      if (ret_valid && pend[ret_tag] >= 0) pend[ret_tag] = -1;
      if (fire && iss_wr) pend[t] = int'(iss_dst);
    end
    exp_err = bad;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic alloc_one(input logic [5:0] d);
    idle();
    iss_valid = 1; iss_wr = 1; iss_dst = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", full); end
    n_cmp++; if (ret_err !== 1'b0) begin n_err++; $display("FAIL reset_ret_err got %0b want 0", ret_err); end
    n_cmp++; if (iss_tag !== 2'd0) begin n_err++; $display("FAIL reset_tag got %0d want 0", iss_tag); end
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", iss_ready); end
  endtask

  task automatic test_alloc();
    idle();
    iss_valid = 1; iss_wr = 1; iss_dst = 6'h05;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL alloc_ready got %0b want 1", iss_ready); end
    n_cmp++; if (iss_tag !== 2'd0) begin n_err++; $display("FAIL alloc_tag got %0d want 0", iss_tag); end
    step();
    idle();
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL alloc_busy got %0b want 1", busy); end
    n_cmp++; if (iss_tag !== 2'd1) begin n_err++; $display("FAIL alloc_next_tag got %0d want 1", iss_tag); end
  endtask

  task automatic test_bank();
    idle();
    iss_valid = 1; iss_usea = 1; iss_srca = 6'h05;
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL raw_same_bank got %0b want 0", iss_ready); end
    iss_srca = 6'h25;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL raw_other_bank got %0b want 1", iss_ready); end
    iss_usea = 0; iss_wr = 1; iss_dst = 6'h05;
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL waw got %0b want 0", iss_ready); end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      idle();
      iss_valid = 1; iss_wr = 1; iss_dst = 6'(i);
      #1;
      n_cmp++; if (int'(iss_tag) !== i - 1) begin n_err++; $display("FAIL fill_tag got %0d want %0d", iss_tag, i - 1); end
      step();
    end
    idle();
    #1;
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag got %0b want 1", full); end
    n_cmp++; if (iss_tag !== 2'd0) begin n_err++; $display("FAIL full_tag got %0d want 0", iss_tag); end
    iss_valid = 1; iss_wr = 1; iss_dst = 6'h06;
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL full_write got %0b want 0", iss_ready); end
    iss_wr = 0; iss_usea = 1; iss_srca = 6'h10; iss_useb = 1; iss_srcb = 6'h21;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL full_nonwrite got %0b want 1", iss_ready); end
    idle();
  endtask

  task automatic test_retire_issue();
    do_reset();
    alloc_one(6'h11);
    alloc_one(6'h12);
    alloc_one(6'h10);
    ret_valid = 1; ret_tag = 2;
    iss_valid = 1; iss_useb = 1; iss_srcb = 6'h10;
    #1;
    n_cmp++; if (iss_ready !== BYP) begin n_err++; $display("FAIL retire_same_cycle got %0b want %0b", iss_ready, BYP); end
    step();
    ret_valid = 0;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL retire_next_cycle got %0b want 1", iss_ready); end
    n_cmp++; if (iss_tag !== 2'd2) begin n_err++; $display("FAIL retire_freed_tag got %0d want 2", iss_tag); end
    idle();
  endtask

  task automatic test_bad_retire();
    idle();
    ret_valid = 1; ret_tag = 3;
    step();
    idle();
    #1;
    n_cmp++; if (ret_err !== 1'b1) begin n_err++; $display("FAIL bad_retire_pulse got %0b want 1", ret_err); end
    n_cmp++; if (iss_tag !== 2'd2 || busy !== 1'b1) begin n_err++; $display("FAIL bad_retire_state got tag %0d busy %0b want tag 2 busy 1", iss_tag, busy); end
    step();
    n_cmp++; if (ret_err !== 1'b0) begin n_err++; $display("FAIL bad_retire_once got %0b want 0", ret_err); end
  endtask

  task automatic test_flush();
    idle();
    flush = 1; iss_valid = 1; iss_wr = 1; iss_dst = 6'h30;
    ret_valid = 1; ret_tag = 3;
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %0b want 0", iss_ready); end
    step();
    idle();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %0b want 0", busy); end
    n_cmp++; if (iss_tag !== 2'd0) begin n_err++; $display("FAIL flush_tag got %0d want 0", iss_tag); end
    n_cmp++; if (ret_err !== 1'b0) begin n_err++; $display("FAIL flush_ret_err got %0b want 0", ret_err); end
  endtask

  task automatic test_reset_drop();
    alloc_one(6'h07);
    alloc_one(6'h08);
    do_reset();
    ret_valid = 1; ret_tag = 1;
    step();
    idle();
    #1;
    n_cmp++; if (ret_err !== 1'b1) begin n_err++; $display("FAIL reset_drop_err got %0b want 1", ret_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_drop_busy got %0b want 0", busy); end
  endtask

  task automatic test_random();
    logic [5:0] pool[4];
    pool[0] = 6'h01; pool[1] = 6'h02; pool[2] = 6'h21; pool[3] = 6'h05;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_usea  = $urandom_range(0, 1);
      iss_useb  = $urandom_range(0, 1);
      iss_wr    = ($urandom_range(0, 2) != 0);
      iss_srca  = pool[$urandom_range(0, 3)];
      iss_srcb  = pool[$urandom_range(0, 3)];
      iss_dst   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pool[$urandom_range(0, 3)];
      ret_valid = ($urandom_range(0, 2) == 0);
      ret_tag   = 2'($urandom);
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      n_cmp++;
      if (iss_ready !== m_ready() || int'(iss_tag) !== m_tag() ||
          busy !== (m_count() > 0) || full !== (m_count() == N) || ret_err !== exp_err) begin
        n_err++;
        $display("FAIL rand_cycle%0d got rdy %0b tag %0d busy %0b full %0b err %0b want rdy %0b tag %0d busy %0b full %0b err %0b",
                 c, iss_ready, iss_tag, busy, full, ret_err,
                 m_ready(), m_tag(), m_count() > 0, m_count() == N, exp_err);
      end
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    for (int e = 0; e < N; e++) pend[e] = -1;
    exp_err = 0;
    test_reset();
    test_alloc();
    test_bank();
    test_full();
    test_retire_issue();
    test_bad_retire();
    test_flush();
    test_reset_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
